// File: rtl/mem_dev_bridge_if.sv
// Bus bundle between the MEM stage, the device bridge and the peripheral
// channels. The slave modport is the bridge's own view of the bundle. The
// master modport is the environment's view: the CPU side plus the devices.
interface mem_dev_bridge_if #(
    parameter int NDEV = 2
);
    // CPU / MEM-stage side
    logic               cpu_req;
    logic               cpu_we;
    logic [31:0]        cpu_addr;
    logic [31:0]        cpu_wdata;
    logic [3:0]         cpu_be;
    logic               abort;
    logic               dev_hit;
    logic               stall;
    logic [31:0]        cpu_rdata;
    logic               bus_err;

    // Device side
    logic [NDEV-1:0]    dev_sel;
    logic [31:0]        dev_addr;
    logic               dev_we;
    logic [31:0]        dev_wdata;
    logic [NDEV*32-1:0] dev_rdata;
    logic [NDEV-1:0]    dev_ack;
    logic [NDEV-1:0]    dev_irq;
    logic [5:0]         hwint;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be, abort,
        input  dev_rdata, dev_ack, dev_irq,
        output dev_hit, stall, cpu_rdata, bus_err,
        output dev_sel, dev_addr, dev_we, dev_wdata, hwint
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be, abort,
        output dev_rdata, dev_ack, dev_irq,
        input  dev_hit, stall, cpu_rdata, bus_err,
        input  dev_sel, dev_addr, dev_we, dev_wdata, hwint
    );
endinterface

// File: rtl/mem_dev_bridge.sv
// MEM-stage system bridge. Word accesses at or above DEV_BASE are routed to
// one of NDEV device channels and the pipeline is stalled until the device
// acks. Unmapped or non-word accesses, and accesses that go unacknowledged
// for TIMEOUT cycles, finish with a one-cycle bus_err pulse. Device
// interrupt levels are registered into hwint.
//
// Device handshake: while a channel's dev_sel bit is high, dev_addr, dev_we
// and dev_wdata are held stable. The device completes the access by driving
// its dev_ack bit high, together with dev_rdata for reads, in a cycle where
// its dev_sel bit is high. The bridge samples dev_ack only in that window
// and drops dev_sel in the following cycle. An ack on any other channel, or
// outside that window, has no effect.
module mem_dev_bridge #(
    parameter int          NDEV     = 2,
    parameter logic [31:0] DEV_BASE = 32'h0000_7F00,
    parameter logic [31:0] DEV_SPAN = 32'h10,
    parameter int          TIMEOUT  = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_dev_bridge_if.slave       bus,
    output logic [1:0]            dbg_state
);
    localparam int CW      = (NDEV > 1) ? $clog2(NDEV) : 1;
    localparam int SPAN_SH = $clog2(DEV_SPAN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [7:0]        cnt_q;
    logic              err_q;
    logic [CW-1:0]     chan_q;
    logic [NDEV-1:0]   sel_q;
    logic [31:0]       addr_q;
    logic              we_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [5:0]        hwint_q;

    logic [31:0]       offset;
    logic [31:0]       chan_full;
    logic              mapped;
    logic              legal;
    logic              hit;
    logic              launch;
    logic              ack_sel;
    logic [31:0]       rdata_sel;
    logic [5:0]        irq_ext;

    // Address decode of the current CPU request and selection of the
    // in-flight channel's ack and read data.
    always_comb begin
        offset    = bus.cpu_addr - DEV_BASE;
        chan_full = offset >> SPAN_SH;
        mapped    = chan_full < 32'(NDEV);
        legal     = mapped && (bus.cpu_be == 4'hF) && (bus.cpu_addr[1:0] == 2'b00);
        hit       = bus.cpu_req && (bus.cpu_addr >= DEV_BASE);
        launch    = (state == IDLE) && hit && !bus.abort;
        ack_sel   = 1'b0;
        rdata_sel = 32'h0;
        for (int i = 0; i < NDEV; i++) begin
            if (chan_q == CW'(i)) begin
                ack_sel   = bus.dev_ack[i];
                rdata_sel = bus.dev_rdata[32*i +: 32];
            end
        end
    end

    // Access sequencer: launch, wait for ack or timeout, one retire cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
            chan_q  <= '0;
            sel_q   <= '0;
            addr_q  <= 32'h0;
            we_q    <= 1'b0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (launch) begin
                        if (legal) begin
                            addr_q  <= {bus.cpu_addr[31:2], 2'b00};
                            we_q    <= bus.cpu_we;
                            wdata_q <= bus.cpu_wdata;
                            chan_q  <= chan_full[CW-1:0];
                            sel_q   <= NDEV'(1) << chan_full[CW-1:0];
                            state   <= WAIT;
                        end else begin
                            // Illegal access never reaches a device.
                            err_q   <= 1'b1;
                            rdata_q <= 32'h0;
                            state   <= DONE;
                        end
                    end
                end
                WAIT: begin
                    if (ack_sel) begin
                        rdata_q <= we_q ? 32'h0 : rdata_sel;
                        sel_q   <= '0;
                        state   <= DONE;
                    end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                        // No ack within the budget: a timed-out write is dropped.
                        err_q   <= 1'b1;
                        rdata_q <= 32'h0;
                        sel_q   <= '0;
                        state   <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                DONE: begin
                    err_q <= 1'b0;
                    cnt_q <= 8'd0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Zero-extend the device interrupt lines to the six CP0 inputs.
    always_comb begin
        irq_ext = 6'b0;
        for (int i = 0; i < NDEV; i++) begin
            irq_ext[i] = bus.dev_irq[i];
        end
    end

    // Interrupt lines are registered every cycle regardless of FSM state.
    always_ff @(posedge clk) begin
        if (reset) begin
            hwint_q <= 6'b0;
        end else begin
            hwint_q <= irq_ext;
        end
    end

    // In IDLE the stall is combinational so the request cycle itself freezes.
    assign bus.dev_hit   = hit;
    assign bus.stall     = launch || (state == WAIT);
    assign bus.cpu_rdata = rdata_q;
    assign bus.bus_err   = err_q && (state == DONE);
    assign bus.dev_sel   = sel_q;
    assign bus.dev_addr  = addr_q;
    assign bus.dev_we    = we_q;
    assign bus.dev_wdata = wdata_q;
    assign bus.hwint     = hwint_q;
    assign dbg_state     = state;
endmodule

// File: tb/tb_mem_dev_bridge.sv
// Testbench for mem_dev_bridge: directed cases for the main access shapes,
// then randomized traffic, checked through an expected-response queue.
module tb_mem_dev_bridge;
    localparam int          NDEV = 2;
    localparam logic [31:0] BASE = 32'h0000_7F00;
    localparam logic [31:0] SPAN = 32'h10;
    localparam int          TO   = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] dbg_state;

    mem_dev_bridge_if #(.NDEV(NDEV)) bus();

    mem_dev_bridge #(
        .NDEV(NDEV), .DEV_BASE(BASE), .DEV_SPAN(SPAN), .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    typedef struct {
        logic            hit;
        logic [31:0]     stall_n;
        logic            err;
        logic            chk_rdata;
        logic [31:0]     rdata;
        logic [NDEV-1:0] sel;
        logic [31:0]     addr;
        logic            we;
        logic [31:0]     wdata;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          mon_en   = 1'b0;
    bit          hw_en    = 1'b0;
    bit          irq_rand = 1'b1;
    int          cur_lat  = 0;
    logic [31:0] cur_rdata = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    // Reference behaviour of one access, straight from the address map rules.
    function automatic exp_t model(input logic we, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [3:0] be,
                                   input logic ab, input int lat, input logic [31:0] rd);
        exp_t        e;
        logic [31:0] chan;
        e = '{default: '0};
        e.addr  = {addr[31:2], 2'b00};
        e.we    = we;
        e.wdata = wdata;
        e.hit   = (addr >= BASE);
        if (!e.hit || ab) return e;
        chan = (addr - BASE) / SPAN;
        if (chan >= 32'(NDEV) || be != 4'hF || addr % 4 != 0) begin
            e.stall_n = 1;
            e.err     = 1'b1;
            return e;
        end
        e.sel       = NDEV'(1) << chan;
        e.chk_rdata = 1'b1;
        if (lat < TO) begin
            e.stall_n = 32'(2 + lat);
            e.rdata   = we ? 32'h0 : rd;
        end else begin
            e.stall_n = 32'(1 + TO);
            e.err     = 1'b1;
            e.rdata   = 32'h0;
        end
        return e;
    endfunction

    // ---------------- device responder ----------------
    int              sel_cnt = 0;
    logic [NDEV-1:0] noise;
    always @(posedge clk) begin
        #1;
        noise = NDEV'($urandom) & ~bus.dev_sel;
        if (bus.dev_sel != '0) begin
            bus.dev_ack = noise | ((sel_cnt == cur_lat) ? bus.dev_sel : '0);
            sel_cnt++;
        end else begin
            bus.dev_ack = noise;
            sel_cnt = 0;
        end
        for (int i = 0; i < NDEV; i++)
            bus.dev_rdata[32*i +: 32] = bus.dev_sel[i] ? cur_rdata : $urandom;
        if (irq_rand) bus.dev_irq = NDEV'($urandom);
    end

    // ---------------- driver ----------------
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input logic ab, input int lat,
                          input logic [31:0] rd);
        int n;
        exp_q.push_back(model(we, addr, wdata, be, ab, lat, rd));
        cur_lat       = lat;
        cur_rdata     = rd;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        bus.cpu_be    = be;
        bus.abort     = ab;
        n = 0;
        forever begin
            @(negedge clk);
            if (!bus.stall) break;
            n++;
            if (n > 40) begin
                n_checks++;
                n_fail++;
                $display("FAIL txn_timeout: stall still high after %0d cycles, expected release", n);
                break;
            end
            @(posedge clk);
            #1;
            // abort after launch must be ignored
            bus.abort = ($urandom_range(0, 3) == 0);
        end
        @(posedge clk);
        #1;
        bus.cpu_req   = 1'b0;
        bus.abort     = 1'b0;
        bus.cpu_addr  = $urandom;
        bus.cpu_wdata = $urandom;
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    int   mcnt = 0;
    exp_t mon_e;
    always @(negedge clk) begin
        if (mon_en) begin
            if (!bus.cpu_req) begin
                check("idle_stall", 32'(bus.stall), 32'h0);
                check("idle_hit", 32'(bus.dev_hit), 32'h0);
                check("idle_sel", 32'(bus.dev_sel), 32'h0);
                check("idle_err", 32'(bus.bus_err), 32'h0);
            end else if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL no_expect: request seen with empty expected queue, expected none");
            end else if (bus.stall) begin
                check("wait_hit", 32'(bus.dev_hit), 32'(exp_q[0].hit));
                check("wait_err", 32'(bus.bus_err), 32'h0);
                if (mcnt == 0) begin
                    check("req_sel", 32'(bus.dev_sel), 32'h0);
                end else begin
                    check("wait_sel", 32'(bus.dev_sel), 32'(exp_q[0].sel));
                    check("dev_addr", bus.dev_addr, exp_q[0].addr);
                    check("dev_we", 32'(bus.dev_we), 32'(exp_q[0].we));
                    check("dev_wdata", bus.dev_wdata, exp_q[0].wdata);
                end
                mcnt++;
            end else begin
                mon_e = exp_q.pop_front();
                check("dev_hit", 32'(bus.dev_hit), 32'(mon_e.hit));
                check("stall_cycles", 32'(mcnt), mon_e.stall_n);
                check("bus_err", 32'(bus.bus_err), 32'(mon_e.err));
                check("done_sel", 32'(bus.dev_sel), 32'h0);
                if (mon_e.chk_rdata) check("cpu_rdata", bus.cpu_rdata, mon_e.rdata);
                mcnt = 0;
            end
        end
    end

    // hwint follows dev_irq with one cycle of latency and clears on reset.
    logic [5:0] exp_hwint = 6'b0;
    always @(posedge clk) exp_hwint <= reset ? 6'b0 : 6'(bus.dev_irq);
    always @(negedge clk) if (hw_en) check("hwint", 32'(bus.hwint), 32'(exp_hwint));

    // ---------------- main sequence ----------------
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    int          r_lat;
    initial begin
        reset = 1'b1;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0;
        bus.cpu_wdata = 32'h0; bus.cpu_be = 4'h0; bus.abort = 1'b0;
        bus.dev_ack = '0; bus.dev_rdata = '0; bus.dev_irq = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", 32'(bus.stall), 32'h0);
        check("rst_err", 32'(bus.bus_err), 32'h0);
        check("rst_rdata", bus.cpu_rdata, 32'h0);
        check("rst_sel", 32'(bus.dev_sel), 32'h0);
        check("rst_addr", bus.dev_addr, 32'h0);
        check("rst_we", 32'(bus.dev_we), 32'h0);
        check("rst_wdata", bus.dev_wdata, 32'h0);
        check("rst_hwint", 32'(bus.hwint), 32'h0);
        check("rst_state", 32'(dbg_state), 32'h0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        idle(1);
        hw_en  = 1'b1;

        // directed shapes
        do_txn(1'b1, 32'h7F04, 32'h1234, 4'hF, 1'b0, 0, 32'hDEAD_BEEF);
        do_txn(1'b0, 32'h7F10, 32'h0, 4'hF, 1'b0, 3, 32'hCAFE_BABE);
        do_txn(1'b0, 32'h7F20, 32'h0, 4'hF, 1'b0, 0, 32'h1111_1111);
        do_txn(1'b1, 32'h7F00, 32'hAB, 4'h1, 1'b0, 0, 32'h0);
        do_txn(1'b0, 32'h7F06, 32'h0, 4'hF, 1'b0, 0, 32'h2222_2222);
        do_txn(1'b0, 32'h7F00, 32'h0, 4'hF, 1'b0, 255, 32'h5555_5555);
        idle(2);
        do_txn(1'b1, 32'h7F00, 32'h1, 4'hF, 1'b1, 0, 32'h0);
        do_txn(1'b0, 32'h0000_0100, 32'h0, 4'hF, 1'b0, 0, 32'h0);
        do_txn(1'b0, 32'h7F1C, 32'h0, 4'hF, 1'b0, TO - 1, 32'h7777_0001);
        do_txn(1'b1, 32'h7F18, 32'h9, 4'hF, 1'b0, TO, 32'h0);

        // randomized traffic
        for (int t = 0; t < 250; t++) begin
            case ($urandom_range(0, 5))
                0:       r_addr = 32'($urandom_range(0, 32'h7EFF)) & ~32'h3;
                1:       r_addr = BASE + 32'($urandom_range(0, 63));
                2:       r_addr = $urandom | 32'h8000_0000;
                default: r_addr = BASE + 32'($urandom_range(0, NDEV * 4 - 1)) * 4;
            endcase
            r_be  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
            r_lat = ($urandom_range(0, 9) == 0) ? 255 : $urandom_range(0, 5);
            do_txn(1'($urandom), r_addr, $urandom, r_be,
                   ($urandom_range(0, 9) == 0), r_lat, $urandom);
            idle($urandom_range(0, 2));
        end
        check("exp_q_empty", 32'(exp_q.size()), 32'h0);

        // interrupt latency
        irq_rand    = 1'b0;
        bus.dev_irq = 2'b10;
        @(posedge clk);
        @(negedge clk);
        check("hwint_irq10", 32'(bus.hwint), 32'h02);

        // reset while an access is waiting on a silent device
        @(posedge clk);
        #1;
        mon_en        = 1'b0;
        cur_lat       = 255;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 32'h7F10;
        bus.cpu_be    = 4'hF;
        bus.abort     = 1'b0;
        idle(3);
        @(negedge clk);
        check("pre_rst_sel", 32'(bus.dev_sel), 32'h2);
        @(posedge clk);
        #1;
        reset       = 1'b1;
        bus.cpu_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("wrst_sel", 32'(bus.dev_sel), 32'h0);
        check("wrst_stall", 32'(bus.stall), 32'h0);
        check("wrst_hwint", 32'(bus.hwint), 32'h0);
        check("wrst_state", 32'(dbg_state), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "time limit");
    end
endmodule

// File: doc/mem_dev_bridge.md
Name: mem_dev_bridge

Overview:
- Parametrised MEM-stage system bridge that replaces the fixed single-window device decode.
- Routes word accesses at or above DEV_BASE to one of NDEV peripheral channels using a req/ack handshake, so devices may insert wait states.
- Raises stall to freeze the pipeline until the access completes, flags bus errors (unmapped, non-word, timeout) to the exception logic, and registers device interrupt lines into HWInt.
- DM accesses (address below DEV_BASE) pass untouched; the block only reports dev_hit for the MEM write-back mux.

Parameters:
- NDEV, 2, number of device channels (1..6).
- DEV_BASE, 32'h0000_7F00, first device byte address.
- DEV_SPAN, 32'h10, bytes per channel window; power of two, at least 4.
- TIMEOUT, 15, maximum wait cycles for dev_ack before bus error (1..255).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  MEM stage holds a load/store this cycle.
- cpu_we  in  1  store when 1.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  forwarded store data.
- cpu_be  in  4  byte enables.
- abort  in  1  IntExcReq this cycle; suppresses launch.
- dev_hit  out  1  cpu_req and cpu_addr >= DEV_BASE (combinational).
- stall  out  1  freeze pipeline.
- cpu_rdata  out  32  device read data, valid in DONE.
- bus_err  out  1  one-cycle error pulse in DONE.
- dev_sel  out  NDEV  one-hot channel strobe.
- dev_addr  out  32  {latched addr[31:2], 2'b00}.
- dev_we  out  1  latched write enable.
- dev_wdata  out  32  latched store data.
- dev_rdata  in  NDEV*32  channel i occupies bits [32i+31:32i].
- dev_ack  in  NDEV  per-channel completion.
- dev_irq  in  NDEV  per-channel interrupt level.
- hwint  out  6  registered interrupts to CP0.

Behaviour:
- Reset values: state IDLE; stall 0; bus_err 0; cpu_rdata 0; dev_sel 0; dev_addr, dev_we, dev_wdata 0; hwint 0; wait counter 0.
- Decode:
  - chan = (cpu_addr - DEV_BASE) / DEV_SPAN.
  - mapped = chan < NDEV.
  - legal = mapped && cpu_be == 4'hF && cpu_addr[1:0] == 0.
- State IDLE:
  - stall = dev_hit && !abort (combinational).
  - At the edge with dev_hit && !abort && legal: latch addr/we/wdata/chan, go WAIT.
  - At the edge with dev_hit && !abort && !legal: go DONE with err flag set, no dev_sel.
  - dev_hit && abort: stall 0, nothing launched, no device side effect.
- State WAIT:
  - stall = 1; dev_sel[chan] = 1; dev_addr, dev_we, dev_wdata held stable.
  - abort is ignored once launched.
  - At the edge with dev_ack[chan]: capture dev_rdata[chan] into cpu_rdata (0 for writes), go DONE.
  - Else increment counter. When counter == TIMEOUT-1 with no ack: go DONE with err flag set and cpu_rdata = 0.
  - A write that times out is considered dropped.
  - Acks on other channels are ignored.
- State DONE:
  - stall = 0; dev_sel = 0; bus_err = err flag (1 cycle); instruction retires at this edge.
  - Next state is IDLE. The counter and err flag clear.
- Latency:
  - Zero-wait device (ack in first WAIT cycle): 2 stall cycles, then DONE.
  - Illegal access: 1 stall cycle, then DONE with bus_err.
- A request with dev_hit = 0 never stalls; outputs stay idle.
- hwint[i] <= dev_irq[i] each cycle for i < NDEV; higher bits are 0. One cycle of latency, independent of FSM state.
- Reset asserted in any state: next cycle IDLE with all reset values. An in-flight access is abandoned without ack.
- The device must hold dev_ack for at least the cycle it is sampled. The bridge samples it only in WAIT.

Test Plan:
- NDEV=2, sw to 0x7F04 data 0x1234, dev_ack[0] in first WAIT cycle -> dev_sel=01, dev_addr=0x7F04, dev_we=1, dev_wdata=0x1234; stall high 2 cycles; bus_err 0.
- lw 0x7F10, channel 1 acks after 3 wait cycles with 0xCAFEBABE -> stall 5 cycles; cpu_rdata=0xCAFEBABE in DONE; dev_sel=10 throughout WAIT.
- lw 0x7F20 (chan 2 >= NDEV) or sb 0x7F00 with be=0001 -> 1 stall cycle; bus_err pulse; dev_sel never asserted.
- Channel 0 never acks, TIMEOUT=15 -> 15 WAIT cycles; bus_err=1 in DONE; cpu_rdata=0; then IDLE.
- sw 0x7F00 with abort=1 in request cycle -> stall 0; dev_sel stays 0; state stays IDLE.
- dev_irq=2'b10 -> hwint=6'b000010 one cycle later. Reset asserted during WAIT -> next cycle dev_sel=0, stall=0, hwint=0.
